diff_tdm_scheduler: RTL and testbench

- Time-multiplexes one signed first-difference datapath (out = x[n] - x[n-1]) across NUM_CH input channels.
- A round-robin arbiter grants one requesting channel per accepted cycle and keeps per-channel history registers.
- Results go out through a single registered valid/ready stream tagged with the channel index.
- Sits between multi-channel sample sources and the shared downstream filter chain; replaces NUM_CH separate differentiators.

---
 rtl/diff_tdm_scheduler.sv | 132 +++++++++++++
 tb/tb_diff_tdm_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/diff_tdm_scheduler.sv
// Purpose: one shared first-difference datapath, time-multiplexed across NUM_CH round-robin channels.
// Latency: 1 cycle from accept to out_valid; 1 result/cycle with out_ready held high.
// Backpressure: a full slot with out_ready low drops all in_ready bits and holds the output.
module diff_tdm_scheduler #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_CH     = 4,
   parameter int CH_BITS    = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_CH-1:0]            in_valid,
   input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
   output logic [NUM_CH-1:0]            in_ready,
   input  logic [NUM_CH-1:0]            ch_clear,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic [CH_BITS-1:0]           out_ch,
   output logic                         out_first
);

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   logic [0:0]            state_q, state_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [CH_BITS-1:0]    ch_q, ch_d;
   logic                  first_q, first_d;
   logic [CH_BITS-1:0]    rr_ptr_q, rr_ptr_d;
   logic [DATA_WIDTH-1:0] z1_q [NUM_CH];
   logic [DATA_WIDTH-1:0] z1_d [NUM_CH];
   logic [NUM_CH-1:0]     fresh_q, fresh_d;

   logic [DATA_WIDTH-1:0] samp [NUM_CH];
   logic                  gnt_vld;
   logic [CH_BITS-1:0]    gnt_idx;
   logic                  slot_free;
   logic                  accept;
   logic [DATA_WIDTH-1:0] hist;

   // Unpack the flat sample bus into one word per channel.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         samp[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Round-robin search starting at rr_ptr; descending loop leaves the closest requester.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         int idx;
         idx = (int'(rr_ptr_q) + k) % NUM_CH;
         if (in_valid[idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = CH_BITS'(idx);
         end
      end
   end

   assign slot_free = (state_q == ST_EMPTY) | out_ready;
   assign accept    = gnt_vld & slot_free & ~rst;
   assign hist      = ch_clear[gnt_idx] ? '0 : z1_q[gnt_idx];

   // Only the granted channel sees ready, and only when the slot can take a result.
   always_comb begin
      in_ready = '0;
      if (accept) begin
         in_ready[gnt_idx] = 1'b1;
      end
   end

   // Next-state: load the slot on accept, drain it on out_ready, apply history clears.
   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      ch_d     = ch_q;
      first_d  = first_q;
      rr_ptr_d = rr_ptr_q;
      fresh_d  = fresh_q;
      for (int i = 0; i < NUM_CH; i++) begin
         z1_d[i] = z1_q[i];
         if (ch_clear[i]) begin
            z1_d[i]    = '0;
            fresh_d[i] = 1'b1;
         end
      end
      if (accept) begin
         state_d          = ST_FULL;
         data_d           = samp[gnt_idx] - hist;
         ch_d             = gnt_idx;
         first_d          = fresh_q[gnt_idx] | ch_clear[gnt_idx];
         z1_d[gnt_idx]    = samp[gnt_idx];
         fresh_d[gnt_idx] = 1'b0;
         rr_ptr_d         = (gnt_idx == CH_BITS'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
      end else if (out_ready) begin
         state_d = ST_EMPTY;
      end
   end

   // State registers; reset discards any pending result and all channel history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_EMPTY;
         data_q   <= '0;
         ch_q     <= '0;
         first_q  <= 1'b0;
         rr_ptr_q <= '0;
         fresh_q  <= '1;
         for (int i = 0; i < NUM_CH; i++) begin
            z1_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         ch_q     <= ch_d;
         first_q  <= first_d;
         rr_ptr_q <= rr_ptr_d;
         fresh_q  <= fresh_d;
         for (int i = 0; i < NUM_CH; i++) begin
            z1_q[i] <= z1_d[i];
         end
      end
   end

   assign out_valid = (state_q == ST_FULL);
   assign out_data  = data_q;
   assign out_ch    = ch_q;
   assign out_first = first_q;

endmodule

// File: tb/tb_diff_tdm_scheduler.sv
// Bench for diff_tdm_scheduler: directed scenarios against a cycle model and literal expectations.
module tb_diff_tdm_scheduler;

   localparam int DW = 16;
   localparam int NC = 4;
   localparam int CB = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [NC-1:0]    in_valid = '0;
   logic [NC*DW-1:0] in_data;
   logic [NC-1:0]    in_ready;
   logic [NC-1:0]    ch_clear = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [DW-1:0]    out_data;
   logic [CB-1:0]    out_ch;
   logic             out_first;

   logic [DW-1:0]    smp [NC];

   int n_checks = 0;
   int n_err    = 0;

   typedef struct packed {
      logic [3:0]    ch;
      logic [DW-1:0] data;
      logic          first;
   } ent_t;
   ent_t log_q [$];

   // Model state
   bit            m_vld;
   logic [DW-1:0] m_data;
   int            m_ch;
   bit            m_first;
   logic [DW-1:0] m_z1 [NC];
   bit            m_fresh [NC];
   int            m_rr;

   diff_tdm_scheduler #(.DATA_WIDTH(DW), .NUM_CH(NC), .CH_BITS(CB)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .ch_clear(ch_clear), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_ch(out_ch), .out_first(out_first)
   );

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < NC; i++) in_data[i*DW +: DW] = smp[i];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Cycle model: checks outputs against the model, then advances it with the inputs seen this cycle.
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_out_valid", {31'd0, out_valid}, 0);
         chk("rst_out_data", {16'd0, out_data}, 0);
         chk("rst_in_ready", {28'd0, in_ready}, 0);
         m_vld = 0; m_data = '0; m_ch = 0; m_first = 0; m_rr = 0;
         for (int i = 0; i < NC; i++) begin m_z1[i] = '0; m_fresh[i] = 1; end
      end else begin
         bit            found, free;
         int            g;
         logic [DW-1:0] h;
         logic [NC-1:0] exp_rdy;
         chk("out_valid", {31'd0, out_valid}, {31'd0, m_vld});
         if (m_vld) begin
            chk("out_data", {16'd0, out_data}, {16'd0, m_data});
            chk("out_ch", {30'd0, out_ch}, m_ch);
            chk("out_first", {31'd0, out_first}, {31'd0, m_first});
         end
         found = 0; g = 0;
         for (int k = 0; k < NC; k++) begin
            int idx;
            idx = (m_rr + k) % NC;
            if (!found && in_valid[idx]) begin found = 1; g = idx; end
         end
         free = !m_vld || out_ready;
         exp_rdy = '0;
         if (found && free) exp_rdy[g] = 1'b1;
         chk("in_ready", {28'd0, in_ready}, {28'd0, exp_rdy});
         if (out_valid && out_ready) log_q.push_back('{ch: {2'b00, out_ch}, data: out_data, first: out_first});
         if (found && free) begin
            h       = ch_clear[g] ? '0 : m_z1[g];
            m_data  = smp[g] - h;
            m_ch    = g;
            m_first = m_fresh[g] || ch_clear[g];
            m_vld   = 1;
         end else if (out_ready) begin
            m_vld = 0;
         end
         for (int i = 0; i < NC; i++) begin
            if (found && free && i == g) begin
               m_z1[i] = smp[i]; m_fresh[i] = 0;
            end else if (ch_clear[i]) begin
               m_z1[i] = '0; m_fresh[i] = 1;
            end
         end
         if (found && free) m_rr = (g + 1) % NC;
      end
   end

   // One clock: capture the accept mask before the edge, return 1 time unit after it.
   task automatic step(output logic [NC-1:0] acc);
      @(negedge clk);
      acc = in_ready & in_valid;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      logic [NC-1:0] a;
      for (int i = 0; i < n; i++) step(a);
   endtask

   task automatic send(input int ch, input logic [DW-1:0] d, input bit clr);
      logic [NC-1:0] a;
      int n;
      n = 0;
      smp[ch] = d; in_valid[ch] = 1'b1; ch_clear[ch] = clr;
      do begin
         step(a);
         ch_clear = '0;
         n++;
      end while (!a[ch] && n < 20);
      in_valid[ch] = 1'b0;
      if (!a[ch]) begin
         n_checks++; n_err++;
         $display("FAIL send_timeout: ch %0d not accepted, got none expected accept", ch);
      end
   endtask

   task automatic chk_log(input string nm, input int idx, input int ch, input logic [DW-1:0] d, input bit f);
      if (idx < log_q.size()) begin
         chk({nm, "_ch"}, {28'd0, log_q[idx].ch}, ch);
         chk({nm, "_data"}, {16'd0, log_q[idx].data}, {16'd0, d});
         chk({nm, "_first"}, {31'd0, log_q[idx].first}, {31'd0, f});
      end else begin
         n_checks++; n_err++;
         $display("FAIL %s_missing: got %0d results expected > %0d", nm, log_q.size(), idx);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      log_q.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NC-1:0] a;
      int cnt [NC];
      for (int i = 0; i < NC; i++) smp[i] = '0;

      // Reset state, literal
      #2;
      chk("reset_valid_lit", {31'd0, out_valid}, 0);
      chk("reset_ready_lit", {28'd0, in_ready}, 0);
      do_reset();

      // T1: ch0 100, 250, 240
      send(0, 16'd100, 0);
      chk("t1_latency", {31'd0, out_valid}, 1);
      send(0, 16'd250, 0);
      send(0, 16'd240, 0);
      idle(2);
      chk("t1_count", log_q.size(), 3);
      chk_log("t1_r0", 0, 0, 16'd100, 1);
      chk_log("t1_r1", 1, 0, 16'd150, 0);
      chk_log("t1_r2", 2, 0, 16'hFFF6, 0);

      // T2: all channels valid, sample n of ch i = 10*(i+1)*n
      do_reset();
      for (int i = 0; i < NC; i++) begin cnt[i] = 0; smp[i] = '0; end
      in_valid = '1;
      for (int c = 0; c < 8; c++) begin
         step(a);
         for (int i = 0; i < NC; i++) if (a[i]) begin
            cnt[i]++;
            smp[i] = DW'(10 * (i + 1) * cnt[i]);
         end
      end
      in_valid = '0;
      idle(2);
      chk("t2_count", log_q.size(), 8);
      for (int i = 0; i < NC; i++) begin
         chk_log("t2_rnd1", i, i, 16'd0, 1);
         chk_log("t2_rnd2", i + 4, i, DW'(10 * (i + 1)), 0);
      end

      // T3: backpressure with slot full, ch1 and ch2 waiting
      log_q.delete();
      out_ready = 1'b0;
      send(0, 16'd15, 0);
      smp[1] = 16'd100; smp[2] = 16'd200;
      in_valid = 4'b0110;
      for (int c = 0; c < 3; c++) begin
         step(a);
         chk("t3_no_ready", {28'd0, a}, 0);
         chk("t3_hold", {16'd0, out_data}, 5);
      end
      out_ready = 1'b1;
      for (int c = 0; c < 10 && in_valid != '0; c++) begin
         step(a);
         in_valid = in_valid & ~a;
      end
      in_valid = '0;
      idle(2);
      chk("t3_count", log_q.size(), 3);
      chk_log("t3_r0", 0, 0, 16'd5, 0);
      chk_log("t3_r1", 1, 1, 16'd80, 0);
      chk_log("t3_r2", 2, 2, 16'd170, 0);

      // T4: wrap-around subtraction on ch2
      log_q.delete();
      send(2, 16'h8000, 0);
      send(2, 16'h7FFF, 0);
      idle(2);
      chk_log("t4_r0", 0, 2, 16'h7F38, 0);
      chk_log("t4_r1", 1, 2, 16'hFFFF, 0);

      // T5: clear coincident with accept on ch3
      log_q.delete();
      send(3, 16'd200, 0);
      send(3, 16'd500, 1);
      send(3, 16'd520, 0);
      idle(2);
      chk_log("t5_r0", 0, 3, 16'd160, 0);
      chk_log("t5_r1", 1, 3, 16'd500, 1);
      chk_log("t5_r2", 2, 3, 16'd20, 0);

      // T6: reset while a result is stuck in the slot
      out_ready = 1'b0;
      send(0, 16'd33, 0);
      chk("t6_full", {31'd0, out_valid}, 1);
      rst = 1'b1;
      #1;
      chk("t6_drop", {31'd0, out_valid}, 0);
      idle(1);
      rst = 1'b0;
      out_ready = 1'b1;
      log_q.delete();
      send(0, 16'd7, 0);
      idle(2);
      chk("t6_count", log_q.size(), 1);
      chk_log("t6_r0", 0, 0, 16'd7, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
